// File: rtl/ifu_prefetch_pkg.sv
// Shared widths, reset PC, PC stride and redirect-source encoding for the fetch unit.
package ifu_prefetch_pkg;

  localparam int          IFU_ADDR_W   = 32;
  localparam int          IFU_INST_W   = 32;
  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
  localparam int          IFU_PC_INC   = 4;

  typedef enum logic [1:0] {
    REDIR_NONE  = 2'd0,
    REDIR_JUMP  = 2'd1,
    REDIR_FLUSH = 2'd2
  } redir_e;

  // Flush from pipe_ctrl outranks a jump from the decoder.
  function automatic redir_e redir_sel(input logic flush, input logic jump);
    if (flush)     return REDIR_FLUSH;
    else if (jump) return REDIR_JUMP;
    else           return REDIR_NONE;
  endfunction

endpackage

// File: rtl/ifu_pf_fifo.sv
// Small synchronous FIFO with clear; DEPTH need not be a power of two.
// Push into a full FIFO and pop from an empty one are ignored.
module ifu_pf_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    cnt;
  logic             push_ok, pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy tracking; clear empties the FIFO in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage array; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: sequential PC generator, credit-limited bus issue,
// in-flight address queue and prefetch queue, with redirect discard.
// Optional build macro IFU_PREFETCH_PERF_EN adds fetch/drop/stall counters.
module ifu_prefetch
  import ifu_prefetch_pkg::*;
#(
  parameter int                ADDR_W          = IFU_ADDR_W,
  parameter int                INST_W          = IFU_INST_W,
  parameter int                FIFO_DEPTH      = 4,
  parameter int                MAX_OUTSTANDING = 2,
  parameter logic [ADDR_W-1:0] RESET_PC        = ADDR_W'(IFU_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jtag_halt_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_addr_i,
  input  logic              jump_flag_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  output logic              inst_valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  input  logic              inst_ready_i,
  output logic              ibus_req_o,
  output logic [ADDR_W-1:0] ibus_addr_o,
  input  logic              ibus_gnt_i,
  input  logic              ibus_rvalid_i,
  input  logic [INST_W-1:0] ibus_data_i
`ifdef IFU_PREFETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_o,
  output logic [31:0]       perf_drop_o,
  output logic [31:0]       perf_stall_o
`endif
);

  localparam int OCW = $clog2(MAX_OUTSTANDING + 1);
  localparam int QCW = $clog2(FIFO_DEPTH + 1);
  localparam int EW  = ADDR_W + INST_W;

  redir_e            redir;
  logic              redirect;
  logic [ADDR_W-1:0] redir_tgt;

  logic [ADDR_W-1:0] pc_q;
  logic              req_hold_q;
  logic [OCW-1:0]    drop_q, drop_nxt;

  logic              issue_ok, grant, rsp, rsp_keep, pq_pop;

  logic [ADDR_W-1:0] aq_rdata;
  logic [OCW-1:0]    aq_count;
  logic              aq_full, aq_empty;
  logic [EW-1:0]     pq_rdata;
  logic [QCW-1:0]    pq_count;
  logic              pq_full, pq_empty;

  // Redirect source priority and target select.
  always_comb begin
    redir     = redir_sel(flush_i, jump_flag_i);
    redirect  = (redir != REDIR_NONE);
    redir_tgt = (redir == REDIR_FLUSH) ? flush_addr_i : jump_addr_i;
  end

  // Credit rule: every issued request already owns a prefetch-queue slot, so
  // in-order responses can always be accepted. The address queue count is the
  // outstanding-request count.
  assign issue_ok = !jtag_halt_i && !aq_full && !pq_full &&
                    ((32'(aq_count) + 32'(pq_count)) < 32'(FIFO_DEPTH));

  // A raised request is held until granted so address stays stable; a
  // redirect withdraws it.
  assign ibus_req_o  = !rst && !redirect && (req_hold_q || issue_ok);
  assign ibus_addr_o = pc_q;
  assign grant       = ibus_req_o && ibus_gnt_i;

  assign rsp      = ibus_rvalid_i && !aq_empty;
  assign rsp_keep = rsp && (drop_q == '0) && !redirect;

  assign inst_valid_o = !pq_empty;
  assign inst_o       = pq_rdata[INST_W-1:0];
  assign inst_addr_o  = pq_rdata[EW-1:INST_W];
  assign pq_pop       = inst_valid_o && inst_ready_i && !redirect;

  // Drop count: on redirect every request still in flight after this cycle is
  // stale; otherwise each response retires one pending discard.
  always_comb begin
    drop_nxt = drop_q;
    if (redirect)
      drop_nxt = aq_count + OCW'(grant) - OCW'(rsp);
    else if (rsp && (drop_q != '0))
      drop_nxt = drop_q - 1'b1;
  end

  // PC, pending-request hold and drop counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      req_hold_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      if (redirect)   pc_q <= redir_tgt;
      else if (grant) pc_q <= pc_q + ADDR_W'(IFU_PC_INC);
      req_hold_q <= ibus_req_o && !ibus_gnt_i;
      drop_q     <= drop_nxt;
    end
  end

  // Addresses of issued requests, matched to responses in order.
  ifu_pf_fifo #(.WIDTH(ADDR_W), .DEPTH(MAX_OUTSTANDING)) u_addr_q (
    .clk       (clk),
    .rst       (rst),
    .clear     (1'b0),
    .push      (grant),
    .push_data (pc_q),
    .pop       (rsp),
    .pop_data  (aq_rdata),
    .count     (aq_count),
    .full      (aq_full),
    .empty     (aq_empty)
  );

  // Fetched {pc, instruction} pairs waiting for the decoder.
  ifu_pf_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_pf_q (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect),
    .push      (rsp_keep),
    .push_data ({aq_rdata, ibus_data_i}),
    .pop       (pq_pop),
    .pop_data  (pq_rdata),
    .count     (pq_count),
    .full      (pq_full),
    .empty     (pq_empty)
  );

`ifdef IFU_PREFETCH_PERF_EN
  // Wrapping event counters: grants, discarded responses, starved cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_o <= '0;
      perf_drop_o  <= '0;
      perf_stall_o <= '0;
    end else begin
      perf_fetch_o <= perf_fetch_o + 32'(grant);
      perf_drop_o  <= perf_drop_o + 32'(rsp && !rsp_keep);
      perf_stall_o <= perf_stall_o + 32'(inst_ready_i && !inst_valid_o);
    end
  end
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// Scoreboard bench for ifu_prefetch: directed phases push expected PCs into
// exp_q; a negedge monitor pops and compares on every consumed instruction.
module tb_ifu_prefetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jtag_halt_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] flush_addr_i = '0;
  logic        jump_flag_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_ready_i = 1'b0;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i = 1'b0;
  logic        ibus_rvalid_i = 1'b0;
  logic [31:0] ibus_data_i = '0;
`ifdef IFU_PREFETCH_PERF_EN
  logic [31:0] perf_fetch_o, perf_drop_o, perf_stall_o;
`endif

  always #5 clk = ~clk;

  ifu_prefetch dut (
    .clk           (clk),
    .rst           (rst),
    .jtag_halt_i   (jtag_halt_i),
    .flush_i       (flush_i),
    .flush_addr_i  (flush_addr_i),
    .jump_flag_i   (jump_flag_i),
    .jump_addr_i   (jump_addr_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .inst_addr_o   (inst_addr_o),
    .inst_ready_i  (inst_ready_i),
    .ibus_req_o    (ibus_req_o),
    .ibus_addr_o   (ibus_addr_o),
    .ibus_gnt_i    (ibus_gnt_i),
    .ibus_rvalid_i (ibus_rvalid_i),
    .ibus_data_i   (ibus_data_i)
`ifdef IFU_PREFETCH_PERF_EN
    ,
    .perf_fetch_o  (perf_fetch_o),
    .perf_drop_o   (perf_drop_o),
    .perf_stall_o  (perf_stall_o)
`endif
  );

  int          n_chk = 0, n_fail = 0, n_pop = 0, cyc = 0;
  int          budget = 0, gcnt = 0, pop1_cyc = 0, pop20_cyc = 0;
  bit          rsp_en = 1'b1;
  logic [31:0] pend[$];
  logic [31:0] exp_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_F00D;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(i * 4));
  endtask

  task automatic wait_pops(input int n, input int bound);
    int t = 0;
    while (n_pop < n && t < bound) begin
      tick();
      t++;
    end
    chk("pop_count_reached", 32'(n_pop), 32'(n));
  endtask

  always @(posedge clk) cyc++;

  // Bus model: grants while budget lasts; answers in order one cycle later.
  always begin
    @(posedge clk);
    if (rst) begin
      pend.delete();
    end else begin
      if (ibus_rvalid_i) void'(pend.pop_front());
      if (ibus_req_o && ibus_gnt_i) begin
        pend.push_back(ibus_addr_o);
        gcnt++;
        if (budget > 0) budget--;
      end
    end
    #2;
    ibus_gnt_i    = !rst && (budget > 0);
    ibus_rvalid_i = !rst && rsp_en && (pend.size() > 0);
    ibus_data_i   = (pend.size() > 0) ? mem_word(pend[0]) : 32'h0;
  end

  // Monitor: every consumed head must match the next expected PC.
  always @(negedge clk) begin
    if (!rst && inst_valid_o && inst_ready_i && !flush_i && !jump_flag_i) begin
      n_pop++;
      if (n_pop == 1)  pop1_cyc  = cyc;
      if (n_pop == 20) pop20_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pop: got addr %h expected none", inst_addr_o);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("head_addr", inst_addr_o, e);
        chk("head_data", inst_o, mem_word(e));
      end
    end
  end

  initial begin
    int base, t;
    // Reset values
    repeat (3) tick();
    chk("rst_valid", 32'(inst_valid_o), 32'd0);
    chk("rst_req", 32'(ibus_req_o), 32'd0);
    chk("rst_addr", ibus_addr_o, 32'h8000_0000);

    // Streaming: 20 fetches, back to back once filled
    inst_ready_i = 1'b1;
    budget = 20;
    push_seq(32'h8000_0000, 20);
    rst = 1'b0;
    wait_pops(20, 200);
    chk("stream_gapless", 32'(pop20_cyc - pop1_cyc), 32'd19);
    chk("held_req", 32'(ibus_req_o), 32'd1);
    chk("held_addr", ibus_addr_o, 32'h8000_0050);

    // Backpressure: queue fills to 4 and issue stops
    inst_ready_i = 1'b0;
    base = gcnt;
    budget = 10;
    push_seq(32'h8000_0050, 10);
    repeat (10) tick();
    chk("bp_grants", 32'(gcnt - base), 32'd4);
    chk("bp_req_off", 32'(ibus_req_o), 32'd0);
    chk("bp_head", inst_addr_o, 32'h8000_0050);
    inst_ready_i = 1'b1;
    wait_pops(30, 200);

    // Jump with two requests in flight: both responses discarded
    rsp_en = 1'b0;
    budget = 2;
    t = 0;
    while (budget > 0 && t < 20) begin tick(); t++; end
    tick();
    chk("j_inflight", 32'(pend.size()), 32'd2);
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h8000_0100;
    #1;
    chk("j_req_withdrawn", 32'(ibus_req_o), 32'd0);
    tick();
    jump_flag_i = 1'b0;
    rsp_en = 1'b1;
    budget = 4;
    push_seq(32'h8000_0100, 4);
    wait_pops(34, 200);

    // Flush and jump together: flush target wins; pending request withdrawn
    chk("pre_flush_req", 32'(ibus_req_o), 32'd1);
    flush_i = 1'b1;
    flush_addr_i = 32'h8000_0200;
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h8000_0300;
    #1;
    chk("f_req_withdrawn", 32'(ibus_req_o), 32'd0);
    tick();
    flush_i = 1'b0;
    jump_flag_i = 1'b0;
    budget = 3;
    push_seq(32'h8000_0200, 3);
    wait_pops(37, 200);

    // Grant withheld: request and address stay put
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_req", 32'(ibus_req_o), 32'd1);
      chk("stall_addr", ibus_addr_o, 32'h8000_020C);
    end

    // Halt: pending request still completes, nothing new, queue drains
    jtag_halt_i = 1'b1;
    tick();
    chk("halt_req_held", 32'(ibus_req_o), 32'd1);
    budget = 1;
    push_seq(32'h8000_020C, 1);
    repeat (6) tick();
    chk("halt_req_off", 32'(ibus_req_o), 32'd0);
    chk("halt_pc", ibus_addr_o, 32'h8000_0210);
    chk("halt_drained", 32'(inst_valid_o), 32'd0);
    chk("halt_pops", 32'(n_pop), 32'd38);
    jtag_halt_i = 1'b0;
    budget = 1;
    push_seq(32'h8000_0210, 1);
    wait_pops(39, 200);

    // Reset mid-operation with two queued and two outstanding
    inst_ready_i = 1'b0;
    budget = 2;
    t = 0;
    while ((budget > 0 || pend.size() > 0) && t < 30) begin tick(); t++; end
    tick();
    rsp_en = 1'b0;
    budget = 2;
    t = 0;
    while (budget > 0 && t < 30) begin tick(); t++; end
    tick();
    chk("mr_inflight", 32'(pend.size()), 32'd2);
    chk("mr_valid", 32'(inst_valid_o), 32'd1);
    chk("mr_head", inst_addr_o, 32'h8000_0214);
    rst = 1'b1;
    #1;
    chk("mr_rst_valid", 32'(inst_valid_o), 32'd0);
    chk("mr_rst_req", 32'(ibus_req_o), 32'd0);
    chk("mr_rst_addr", ibus_addr_o, 32'h8000_0000);
    tick();
    tick();
    rsp_en = 1'b1;
    inst_ready_i = 1'b1;
    budget = 2;
    push_seq(32'h8000_0000, 2);
    rst = 1'b0;
    wait_pops(41, 200);

    repeat (5) tick();
    chk("final_pops", 32'(n_pop), 32'd41);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
